// File: rtl/cnt_sched_pkg.sv
// Shared types and constants for the counter scheduler.
// State encodings are fixed so the scheduler state is readable in waveforms.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Wide enough to index up to four requesters.
  localparam int ID_W = 2;

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// Round-robin picker: first asserted req after ptr, wrapping modulo N_REQ.
// Purely combinational, zero latency; no flow control of its own.
module cnt_sched_rr_pick
  import cnt_sched_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Walk the search order backwards so the last match written is the nearest one.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
          grant    = '0;
          grant[i] = 1'b1;
          idx      = ID_W'(i);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cnt_sched.sv
// Shares one enable/clear counter between N_REQ requesters: grant, clear, count to tc, pulse done.
// Grant 1 cycle after req, done tc+2 cycles after grant; requesters wait on their req level.
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 4
) (
  input  logic               CK,
  input  logic               CLR,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] tc,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic               cnt_en,
  output logic               cnt_clr_n,
  input  logic [W-1:0]       cnt_q
);

  state_t            state;
  logic [W-1:0]      tc_lat;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   ptr;

  logic [N_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [W-1:0]      tc_pick;
  logic              owner_req;
  logic              q_match;

  cnt_sched_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    tc_pick   = '0;
    owner_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) tc_pick = tc[i*W +: W];
      if (owner == ID_W'(i))    owner_req = req[i];
    end
  end

  assign q_match = (cnt_q == tc_lat);

  // Enable drops on the match cycle itself, so the counter parks on tc_lat.
  assign cnt_en    = !CLR && (state == S_RUN) && !q_match && owner_req;
  assign cnt_clr_n = !(CLR || (state == S_CLEAR));

  always_ff @(posedge CK) begin
    if (CLR) begin
      state   <= S_IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      ptr     <= ID_W'(N_REQ - 1);
      owner   <= '0;
      tc_lat  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            tc_lat <= tc_pick;
            owner  <= pick_idx;
            grant  <= pick_grant;
            busy   <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_RUN;
        S_RUN: begin
          if (q_match) begin
            done    <= 1'b1;
            done_id <= owner;
            state   <= S_DONE;
          end else if (!owner_req) begin
            // Owner gave up early: release without a done pulse.
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= owner;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// Bench for cnt_sched with a 4-bit enable/clear counter, checked against a phase-timeline model.
// Directed scenarios first, then randomized requesters, tc values, aborts and resets.
module tb_cnt_sched;

  localparam int N = 2;
  localparam int W = 4;

  logic           ck = 1'b0;
  logic           clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] tc;
  logic [N-1:0]   grant;
  logic           busy;
  logic           done;
  logic [1:0]     done_id;
  logic           cnt_en;
  logic           cnt_clr_n;
  logic [W-1:0]   cnt_q;

  always #50 ck = ~ck;

  cnt_sched #(.N_REQ(N), .W(W)) dut (
    .CK        (ck),
    .CLR       (clr),
    .req       (req),
    .tc        (tc),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .cnt_q     (cnt_q)
  );

  // Shared 4-bit counter: synchronous active-low clear, count enable.
  always_ff @(posedge ck) begin
    if (!cnt_clr_n)  cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: an interval is a timeline g = 0 (clear), 1..tc+1 (run), tc+2 (done pulse).
  bit  m_busy;
  int  m_g, m_owner, m_tc, m_ptr, m_q;
  int  cyc, grant_cyc, done_cyc;
  logic [N-1:0] prev_grant;
  int  done_log[$];

  task automatic model_reset();
    m_busy  = 1'b0;
    m_g     = 0;
    m_owner = 0;
    m_ptr   = N - 1;
  endtask

  function automatic logic [N*W-1:0] mk_tc(input int a, input int b);
    return {W'(b), W'(a)};
  endfunction

  task automatic step(input bit c, input logic [N-1:0] r, input logic [N*W-1:0] t);
    int exp_grant, cand;
    bit exp_done, exp_en, exp_clrn, own_req;
    logic [N*W-1:0] ts;
    @(negedge ck);
    clr = c;
    req = r;
    tc  = t;
    #1;
    own_req   = ((r >> m_owner) & N'(1)) != '0;
    exp_grant = m_busy ? (1 << m_owner) : 0;
    exp_done  = m_busy && (m_g == m_tc + 2);
    exp_en    = !c && m_busy && (m_g >= 1) && (m_g <= m_tc) && own_req;
    exp_clrn  = !c && !(m_busy && m_g == 0);
    chk("grant",     32'(grant),     32'(exp_grant));
    chk("busy",      32'(busy),      32'(m_busy));
    chk("done",      32'(done),      32'(exp_done));
    chk("cnt_en",    32'(cnt_en),    32'(exp_en));
    chk("cnt_clr_n", 32'(cnt_clr_n), 32'(exp_clrn));
    chk("cnt_q",     32'(cnt_q),     32'(m_q));
    if (exp_done) chk("done_id", 32'(done_id), 32'(m_owner));
    if (done === 1'b1) begin
      done_log.push_back(int'(done_id));
      done_cyc = cyc;
    end
    if (grant != '0 && prev_grant == '0) grant_cyc = cyc;
    prev_grant = grant;

    if (!exp_clrn)   m_q = 0;
    else if (exp_en) m_q = (m_q + 1) % 16;

    if (c) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = N; k >= 1; k--) begin
        cand = (m_ptr + k) % N;
        if (((r >> cand) & N'(1)) != '0) begin
          m_busy  = 1'b1;
          m_g     = 0;
          m_owner = cand;
          ts      = t >> (cand * W);
          m_tc    = int'(ts[W-1:0]);
        end
      end
    end else if (m_g >= 1 && m_g <= m_tc && !own_req) begin
      m_busy = 1'b0;
      m_ptr  = m_owner;
    end else if (m_g == m_tc + 2) begin
      m_busy = 1'b0;
      m_ptr  = m_owner;
    end else begin
      m_g++;
    end
    cyc++;
  endtask

  initial begin
    int n0;
    logic [N-1:0]   rq;
    logic [N*W-1:0] tv;
    logic [N-1:0]   m;
    bit             cr;
    int             v;

    clr = 1'b1;
    req = '0;
    tc  = '0;
    repeat (2) @(posedge ck);
    model_reset();
    m_q = 0;
    cyc = 0;
    prev_grant = '0;

    // 1: reset state, then idle with no requests
    step(1'b1, '0, '0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    repeat (4) step(1'b0, '0, '0);

    // 2: single requester, tc0=5
    grant_cyc = -1;
    done_cyc  = -1;
    for (int i = 0; i < 20 && done_cyc < 0; i++) step(1'b0, 2'b01, mk_tc(5, 0));
    chk("t2_latency", 32'(done_cyc - grant_cyc), 32'd7);
    chk("t2_q_hold",  32'(cnt_q), 32'd5);
    chk("t2_done_id", 32'(done_id), 32'd0);
    repeat (3) step(1'b0, 2'b00, mk_tc(5, 0));
    chk("t2_q_after", 32'(cnt_q), 32'd5);

    // 3: both requesting from a fresh pointer; service must alternate
    step(1'b1, 2'b00, '0);
    done_log.delete();
    for (int i = 0; i < 60 && done_log.size() < 3; i++) step(1'b0, 2'b11, mk_tc(3, 2));
    chk("t3_ndone", 32'(done_log.size()), 32'd3);
    for (int i = 0; i < done_log.size() && i < 3; i++)
      chk("t3_order", 32'(done_log[i]), (i == 1) ? 32'd1 : 32'd0);
    repeat (3) step(1'b0, 2'b00, '0);

    // 4: tc=0, counter never enabled
    grant_cyc = -1;
    done_cyc  = -1;
    for (int i = 0; i < 20 && done_cyc < 0; i++) step(1'b0, 2'b01, mk_tc(0, 7));
    chk("t4_latency", 32'(done_cyc - grant_cyc), 32'd2);
    chk("t4_q",       32'(cnt_q), 32'd0);
    repeat (2) step(1'b0, 2'b00, '0);

    // 5: tc=15 on requester 1, no wrap
    done_cyc = -1;
    for (int i = 0; i < 40 && done_cyc < 0; i++) step(1'b0, 2'b10, mk_tc(3, 15));
    chk("t5_q",       32'(cnt_q), 32'd15);
    chk("t5_done_id", 32'(done_id), 32'd1);
    repeat (3) step(1'b0, 2'b00, '0);
    chk("t5_no_wrap", 32'(cnt_q), 32'd15);

    // 6a: abort when the counter shows 2
    for (int i = 0; i < 20 && !(busy && cnt_q == 4'd1); i++) step(1'b0, 2'b01, mk_tc(9, 0));
    n0 = done_log.size();
    step(1'b0, 2'b00, mk_tc(9, 0));
    chk("t6_q_at_drop", 32'(cnt_q), 32'd2);
    chk("t6_en_drop",   32'(cnt_en), 32'd0);
    step(1'b0, 2'b00, mk_tc(9, 0));
    chk("t6_abort_idle", 32'(busy), 32'd0);
    chk("t6_no_done",    32'(done_log.size()), 32'(n0));

    // 6b: reset in the middle of a run
    repeat (5) step(1'b0, 2'b01, mk_tc(9, 0));
    step(1'b1, 2'b01, mk_tc(9, 0));
    step(1'b0, 2'b00, mk_tc(9, 0));
    chk("t6_clr_q",     32'(cnt_q), 32'd0);
    chk("t6_clr_grant", 32'(grant), 32'd0);

    // Randomized requesters
    rq = '0;
    for (int n = 0; n < 1500; n++) begin
      tv = '0;
      for (int i = 0; i < N; i++) begin
        m = N'(1) << i;
        if ((rq & m) == '0) begin
          if ($urandom_range(0, 2) == 0) rq = rq | m;
        end else if (done && int'(done_id) == i) begin
          if ($urandom_range(0, 1) == 0) rq = rq & ~m;
        end else if (busy && (grant & m) != '0 && $urandom_range(0, 39) == 0) begin
          rq = rq & ~m;
        end
        case ($urandom_range(0, 3))
          0:       v = 0;
          1:       v = 15;
          default: v = int'($urandom_range(0, 15));
        endcase
        tv = tv | ((N*W)'(v) << (i * W));
      end
      cr = ($urandom_range(0, 299) == 0);
      step(cr, rq, tv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
